match_req_dispatcher: RTL
=========================

Name: match_req_dispatcher

Overview:
- Accepts one lazy-match window of up to LAZY_LEN match requests (offsets plus a per-lane channel route map) and fans each request out to every match-request channel whose route bit is set.
- Per-channel valid/ready handshakes. Each channel drains its requests independently, lowest lane first.
- Sits between the lazy-window sequencer and the NUM_MATCH_REQ_CH match engines.
- Accepts the next window only after every channel has drained the current one.

Parameters:
LAZY_LEN, 4, lanes per window
NUM_MATCH_REQ_CH, 4, number of match-request channels
SEQ_OFFSET_BITS, 21, width of one match offset
WIN_ID_BITS, 8, window tag width
LANE_BITS, 2, lane index width; must satisfy 2^LANE_BITS >= LAZY_LEN

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  window valid
in_ready  output  1  window accepted when in_valid && in_ready
in_offset  input  LAZY_LEN*SEQ_OFFSET_BITS  per-lane offsets, lane i at slice i
in_mask  input  LAZY_LEN  lane i carries a real request
in_route_map  input  LAZY_LEN*NUM_MATCH_REQ_CH  bit i*NUM_MATCH_REQ_CH+j: lane i eligible for channel j
in_win_id  input  WIN_ID_BITS  window tag
ch_valid  output  NUM_MATCH_REQ_CH  request valid per channel
ch_ready  input  NUM_MATCH_REQ_CH  channel accepts
ch_offset  output  NUM_MATCH_REQ_CH*SEQ_OFFSET_BITS  offset of the selected lane
ch_lane  output  NUM_MATCH_REQ_CH*LANE_BITS  selected lane index
ch_win_id  output  NUM_MATCH_REQ_CH*WIN_ID_BITS  tag of the current window
ch_last  output  NUM_MATCH_REQ_CH  this beat is the final request of the window on this channel
unroutable_valid  output  1  one-cycle pulse reporting lanes that were dropped
unroutable_mask  output  LAZY_LEN  lanes with in_mask=1 and no route bit set; valid with the pulse
busy  output  1  state==DISPATCH

Behaviour:
- Reset values: state IDLE, pending matrix 0, latched offsets and tag 0, ch_valid 0, ch_last 0, unroutable_valid 0, unroutable_mask 0, busy 0. in_ready=1 once rst is low.
- Reset mid-DISPATCH discards all pending requests. No further ch_valid is issued.
- FSM states:
  - IDLE: in_ready=1.
  - DISPATCH: in_ready=0.
- Acceptance (IDLE, in_valid high) at edge T:
  - Latch in_offset and in_win_id.
  - pending[i][j] <= in_mask[i] & route[i][j].
  - unroutable_mask <= in_mask & ~(OR over j of route[i][j]).
  - unroutable_valid <= 1 if that mask is nonzero, for exactly one cycle.
- IDLE transitions:
  - If any pending bit is set, go to DISPATCH; ch_valid first asserts in cycle T+1.
  - If no pending bit is set (all lanes masked or unroutable), remain in IDLE with in_ready still 1. Back-to-back windows are legal in this case.
- DISPATCH, for each channel j:
  - ch_valid[j] = OR over i of pending[i][j].
  - sel_j = lowest i with pending[i][j].
  - ch_offset[j] = offset[sel_j]; ch_lane[j] = sel_j; ch_win_id[j] = latched tag.
  - ch_last[j] = popcount(column j)==1.
  - On ch_valid[j] && ch_ready[j], clear pending[sel_j][j].
- Channel independence: channels never stall each other. Multiple channels may hand off the same lane in the same cycle.
- Payload stability: while ch_valid[j]=1 && ch_ready[j]=0, the payload on channel j is stable, because column j changes only on its own handshake. ch_valid never depends combinationally on ch_ready.
- Completion: when the pending matrix becomes all-zero after an edge, the state returns to IDLE. in_ready rises in the cycle after the last handshake, giving one bubble between dispatched windows.
- ch_ready while ch_valid=0 has no effect.
- Offsets pass through unmodified; no arithmetic is performed on them. The route map is trusted as given.
- Minimum window occupancy is max over channels of the column popcount, in cycles, with full ready.

Test Plan:
- Full-ready fan-out: all ch_ready=1, window accepted at T, tag 0x11.
  - Offsets {100, 40000, 70000, 5000}, mask 1111, routes lane0→ch0,1,2; lane1→ch1,3; lane2→ch3; lane3→ch1,2.
  - T+1: ch0 lane0 last, ch1 lane0, ch2 lane0, ch3 lane1.
  - T+2: ch1 lane1, ch2 lane3 last, ch3 lane2 last.
  - T+3: ch1 lane3 last.
  - in_ready=1 at T+4. All beats carry win_id 0x11.
- Backpressure: same window with ch_ready[1]=0 for T+1..T+5.
  - ch1 holds lane0, offset 100 stable; other channels finish by T+2.
  - ch1 then issues lanes 0, 1, 3 at T+6..T+8.
  - in_ready=1 at T+9; busy high throughout.
- Unroutable lanes: mask 1111, lanes 2 and 3 with zero route bits, lane0→ch0, lane1→ch3.
  - unroutable_valid pulses at T+1 with mask 1100.
  - Only lanes 0 and 1 are dispatched.
- All lanes unroutable or masked: in_mask=0000 or all routes zero.
  - No ch_valid; state stays IDLE; in_ready stays 1.
  - A second window on the next cycle is accepted.
- Async reset mid-DISPATCH: assert rst at T+2 of scenario 1.
  - ch_valid, ch_last and busy go to 0 immediately, without waiting for an edge.
  - After release, in_ready=1 and no stale beats appear.
- Sparse mask: mask 0101, all four route bits set on every lane.
  - Every channel issues lane0 then lane2 (last).
  - Lanes 1 and 3 are never issued and unroutable_valid stays 0.

Source files
------------

// File: rtl/match_req_dispatcher.sv
// Lazy-match window dispatcher: latches one window of up to LAZY_LEN match
// requests and fans each lane out to every match-request channel whose route
// bit is set. Each channel drains its own column of the pending matrix,
// lowest lane first, under an independent valid/ready handshake.
//
// Handshake rule, for the window input and for every channel: a transfer
// happens on a rising clk edge where valid && ready. A valid, once raised, is
// held with a stable payload until that transfer happens. valid never depends
// combinationally on ready.
module match_req_dispatcher #(
    parameter int LAZY_LEN         = 4,
    parameter int NUM_MATCH_REQ_CH = 4,
    parameter int SEQ_OFFSET_BITS  = 21,
    parameter int WIN_ID_BITS      = 8,
    parameter int LANE_BITS        = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0]      in_offset,
    input  logic [LAZY_LEN-1:0]                      in_mask,
    input  logic [LAZY_LEN*NUM_MATCH_REQ_CH-1:0]     in_route_map,
    input  logic [WIN_ID_BITS-1:0]                   in_win_id,
    output logic [NUM_MATCH_REQ_CH-1:0]              ch_valid,
    input  logic [NUM_MATCH_REQ_CH-1:0]              ch_ready,
    output logic [NUM_MATCH_REQ_CH*SEQ_OFFSET_BITS-1:0] ch_offset,
    output logic [NUM_MATCH_REQ_CH*LANE_BITS-1:0]    ch_lane,
    output logic [NUM_MATCH_REQ_CH*WIN_ID_BITS-1:0]  ch_win_id,
    output logic [NUM_MATCH_REQ_CH-1:0]              ch_last,
    output logic                                     unroutable_valid,
    output logic [LAZY_LEN-1:0]                      unroutable_mask,
    output logic                                     busy
);

    localparam int NCH = NUM_MATCH_REQ_CH;
    localparam int SOB = SEQ_OFFSET_BITS;
    localparam int PW  = LAZY_LEN * NUM_MATCH_REQ_CH;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] DISPATCH = 1'b1;

    logic [0:0]              state;
    // pending bit i*NCH+j: lane i still owes a request to channel j
    logic [PW-1:0]           pending;
    logic [PW-1:0]           pending_nxt;
    logic [PW-1:0]           accept_pending;
    logic [LAZY_LEN*SOB-1:0] offset_q;
    logic [WIN_ID_BITS-1:0]  win_id_q;
    logic [LAZY_LEN-1:0]     unroutable_nxt;
    logic [LAZY_LEN-1:0]     col [NCH];
    logic [LANE_BITS-1:0]    sel [NCH];
    logic                    accept;

    assign busy     = (state == DISPATCH);
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Decode an incoming window into its pending matrix and its dropped lanes
    always_comb begin
        accept_pending = '0;
        unroutable_nxt = '0;
        for (int i = 0; i < LAZY_LEN; i++) begin
            unroutable_nxt[i] = in_mask[i] & ~(|in_route_map[i*NCH +: NCH]);
            for (int j = 0; j < NCH; j++) begin
                accept_pending[i*NCH+j] = in_mask[i] & in_route_map[i*NCH+j];
            end
        end
    end

    // Per-channel lowest-lane pick, payload mux and handshake clear
    always_comb begin
        pending_nxt = pending;
        ch_valid    = '0;
        ch_last     = '0;
        ch_offset   = '0;
        ch_lane     = '0;
        ch_win_id   = '0;
        for (int j = 0; j < NCH; j++) begin
            col[j] = '0;
            sel[j] = '0;
            for (int i = 0; i < LAZY_LEN; i++) begin
                col[j][i] = pending[i*NCH+j];
            end
            // scan downward so the lowest set lane is the last one written
            for (int i = LAZY_LEN - 1; i >= 0; i--) begin
                if (col[j][i]) begin
                    sel[j] = LANE_BITS'(i);
                end
            end
            ch_valid[j] = busy && (col[j] != '0);
            // exactly one bit left in the column means this is the final beat
            ch_last[j]  = ch_valid[j] && ((col[j] & (col[j] - LAZY_LEN'(1))) == '0);
            ch_offset[j*SOB +: SOB]                 = offset_q[int'(sel[j])*SOB +: SOB];
            ch_lane[j*LANE_BITS +: LANE_BITS]       = sel[j];
            ch_win_id[j*WIN_ID_BITS +: WIN_ID_BITS] = win_id_q;
            if (ch_valid[j] && ch_ready[j]) begin
                pending_nxt[int'(sel[j])*NCH + j] = 1'b0;
            end
        end
    end

    // FSM, window latch and pending-matrix update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pending          <= '0;
            offset_q         <= '0;
            win_id_q         <= '0;
            unroutable_valid <= 1'b0;
            unroutable_mask  <= '0;
        end else begin
            unroutable_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        offset_q         <= in_offset;
                        win_id_q         <= in_win_id;
                        pending          <= accept_pending;
                        unroutable_mask  <= unroutable_nxt;
                        unroutable_valid <= |unroutable_nxt;
                        // a window with nothing routable never leaves IDLE
                        state            <= (|accept_pending) ? DISPATCH : IDLE;
                    end
                end
                default: begin
                    pending <= pending_nxt;
                    if (pending_nxt == '0) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
